// File: rtl/my_seq_pkg.sv
// ---------------------------------------------------------------------------
// my_seq_pkg
// Shared definitions for the serial pattern sequence generator:
//   - seq_state_e : burst controller states
//   - REP_W       : width of the frame (repeat) counter
//   - GAP_W       : width of the inter-frame gap counter (GAP_CYCLES <= 15)
// ---------------------------------------------------------------------------
package my_seq_pkg;

    localparam int REP_W = 4;
    localparam int GAP_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/my_seq_gen_if.sv
// ---------------------------------------------------------------------------
// my_seq_gen_if
// Request/stream bundle of the sequence generator.
//   Requester -> generator : start, pattern, len, repeat_cnt, halt
//   Generator -> requester : out, valid, frame_start, busy, done, aborted
// The repeat count is carried as repeat_cnt because "repeat" is a reserved
// word in SystemVerilog.
// Modports: master (requester side), slave (generator side).
// ---------------------------------------------------------------------------
interface my_seq_gen_if #(
    parameter int PAT_W = 8
);
    import my_seq_pkg::*;

    localparam int LEN_W = $clog2(PAT_W);

    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] repeat_cnt;
    logic             halt;
    logic             out;
    logic             valid;
    logic             frame_start;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start, pattern, len, repeat_cnt, halt,
        input  out, valid, frame_start, busy, done, aborted
    );

    modport slave (
        input  start, pattern, len, repeat_cnt, halt,
        output out, valid, frame_start, busy, done, aborted
    );

endinterface

// File: rtl/my_seq_cnt.sv
// ---------------------------------------------------------------------------
// my_seq_cnt
// Loadable down-counter with zero flag. Load has priority over decrement and
// the count saturates at zero, so it can never wrap.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset (count -> 0)
//   load     : load load_val this cycle
//   load_val : value to load
//   dec      : decrement by one (ignored when already zero)
//   count    : current count
//   zero     : count == 0
// ---------------------------------------------------------------------------
module my_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/my_seq_gen.sv
// ---------------------------------------------------------------------------
// my_seq_gen
// Serial pattern generator. On start (sampled in IDLE) it latches pattern,
// len and repeat_cnt, then sends repeat_cnt+1 frames of len+1 bits each,
// MSB of the active field first, separated by GAP_CYCLES idle cycles.
// All outputs are registered; the first bit appears the cycle after start.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : my_seq_gen_if.slave (start/pattern/len/repeat_cnt/halt in,
//           out/valid/frame_start/busy/done/aborted out)
// Parameters: PAT_W (>= 2, must match the interface), GAP_CYCLES (1..15).
// ---------------------------------------------------------------------------
module my_seq_gen
    import my_seq_pkg::*;
#(
    parameter int PAT_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input logic         clock,
    input logic         reset,
    my_seq_gen_if.slave bus
);

    localparam int LEN_W = $clog2(PAT_W);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             latch;

    logic out_q, valid_q, fs_q, busy_q, done_q, abort_q;
    logic out_d, valid_d, fs_d, busy_d, done_d, abort_d;

    // Bit counter holds the pattern index of the bit currently on out,
    // counting from len down to 0, so its zero flag marks the last bit.
    logic             b_load, b_dec, b_zero;
    logic [LEN_W-1:0] b_load_val, b_cnt;
    logic             g_load, g_dec, g_zero;
    logic [GAP_W-1:0] g_cnt;
    logic             f_load, f_dec, f_zero;
    logic [REP_W-1:0] f_cnt;

    my_seq_cnt #(.W(LEN_W)) u_bit_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (b_load),
        .load_val (b_load_val),
        .dec      (b_dec),
        .count    (b_cnt),
        .zero     (b_zero)
    );

    my_seq_cnt #(.W(GAP_W)) u_gap_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (g_load),
        .load_val (GAP_LOAD),
        .dec      (g_dec),
        .count    (g_cnt),
        .zero     (g_zero)
    );

    my_seq_cnt #(.W(REP_W)) u_frame_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (f_load),
        .load_val (bus.repeat_cnt),
        .dec      (f_dec),
        .count    (f_cnt),
        .zero     (f_zero)
    );

    // Gap and frame counts are only consumed through their zero flags.
    logic unused_cnt_bits;
    assign unused_cnt_bits = ^{g_cnt, f_cnt};

    // Next state and next registered outputs. Output registers take the
    // value for the cycle that follows the edge, hence the look-ahead on
    // pattern bits (b_cnt - 1, or the top of the field on a frame start).
    always_comb begin
        state_d    = state_q;
        latch      = 1'b0;
        out_d      = 1'b0;
        valid_d    = 1'b0;
        fs_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        b_load     = 1'b0;
        b_load_val = len_q;
        b_dec      = 1'b0;
        g_load     = 1'b0;
        g_dec      = 1'b0;
        f_load     = 1'b0;
        f_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                // halt outranks start here: nothing launches.
                if (bus.start && !bus.halt) begin
                    state_d    = SHIFT;
                    latch      = 1'b1;
                    b_load     = 1'b1;
                    b_load_val = bus.len;
                    f_load     = 1'b1;
                    out_d      = bus.pattern[bus.len];
                    valid_d    = 1'b1;
                    fs_d       = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            SHIFT: begin
                if (bus.halt) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (!b_zero) begin
                    b_dec   = 1'b1;
                    out_d   = pat_q[b_cnt - LEN_W'(1)];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (!f_zero) begin
                    state_d = GAP;
                    g_load  = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            GAP: begin
                if (bus.halt) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (g_zero) begin
                    state_d = SHIFT;
                    b_load  = 1'b1;
                    f_dec   = 1'b1;
                    out_d   = pat_q[len_q];
                    valid_d = 1'b1;
                    fs_d    = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    g_dec  = 1'b1;
                    busy_d = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                abort_d = bus.halt;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                pat_q <= bus.pattern;
                len_q <= bus.len;
            end
            out_q   <= out_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.valid       = valid_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = abort_q;

endmodule

// File: tb/tb_my_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_my_seq_gen
// Self-checking bench for my_seq_gen. A reference model expands each burst
// request into the list of per-cycle observations (valid, out, frame_start,
// busy, done, aborted) that should follow the start edge; each scenario task
// drives the DUT and compares cycle by cycle against that list.
// ---------------------------------------------------------------------------
module tb_my_seq_gen;

    localparam int PAT_W = 8;
    localparam int GAP   = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    my_seq_gen_if #(.PAT_W(PAT_W)) bus ();

    my_seq_gen #(
        .PAT_W      (PAT_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic valid;
        logic out;
        logic fs;
        logic busy;
        logic done;
        logic aborted;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t mk(input logic v, input logic o, input logic f,
                                input logic b, input logic d, input logic a);
        obs_t e;
        e.valid   = v;
        e.out     = o;
        e.fs      = f;
        e.busy    = b;
        e.done    = d;
        e.aborted = a;
        return e;
    endfunction

    function automatic obs_t observe();
        return mk(bus.valid, bus.out, bus.frame_start, bus.busy, bus.done, bus.aborted);
    endfunction

    // Expected observations for cycles k+1, k+2, ... after a start at edge k.
    // halt_at >= 0 means halt is held high during that observation cycle.
    function automatic void build_exp(input logic [7:0] p, input int l, input int r,
                                      input int halt_at);
        obs_t q[$];
        for (int f = 0; f <= r; f++) begin
            for (int i = 0; i <= l; i++) q.push_back(mk(1'b1, p[l-i], i == 0, 1'b1, 1'b0, 1'b0));
            if (f < r) for (int g = 0; g < GAP; g++) q.push_back(mk(0, 0, 0, 1, 0, 0));
        end
        q.push_back(mk(0, 0, 0, 1, 1, 0));
        if (halt_at >= 0) begin
            q = q[0:halt_at];
            q.push_back(mk(0, 0, 0, 0, 0, 1));
        end
        q.push_back(mk(0, 0, 0, 0, 0, 0));
        exp_q = q;
    endfunction

    task automatic test_reset();
        obs_t got;
        repeat (3) @(posedge clock);
        #1;
        got = observe();
        checks++;
        if (got !== mk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", got, mk(0, 0, 0, 0, 0, 0));
        end
        reset = 1'b1;
        @(posedge clock); #1;
        got = observe();
        checks++;
        if (got !== mk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_released: got %b expected %b", got, mk(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_halt_idle();
        obs_t got;
        bus.pattern = 8'hFF; bus.len = 3'd7; bus.repeat_cnt = 4'd3;
        bus.start = 1'b1; bus.halt = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clock); #1;
            got = observe();
            checks++;
            if (got !== mk(0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL halt_start_idle[%0d]: got %b expected %b", j, got, mk(0, 0, 0, 0, 0, 0));
            end
        end
        bus.start = 1'b0;
        @(posedge clock); #1;
        bus.halt = 1'b0;
    endtask

    task automatic test_single_frame();
        obs_t got;
        logic [7:0] stream = '0;
        build_exp(8'hB2, 7, 0, -1);
        bus.pattern = 8'hB2; bus.len = 3'd7; bus.repeat_cnt = 4'd0; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = observe();
            if (got.valid) stream = {stream[6:0], got.out};
            checks++;
            if (got !== exp_q[j]) begin
                errors++;
                $display("FAIL single_frame[%0d]: got %b expected %b", j, got, exp_q[j]);
            end
            @(posedge clock); #1;
        end
        checks++;
        if (stream !== 8'hB2) begin
            errors++;
            $display("FAIL single_frame_stream: got %h expected b2", stream);
        end
    endtask

    task automatic test_repeat_gap();
        obs_t got;
        build_exp(8'h05, 2, 1, -1);
        bus.pattern = 8'h05; bus.len = 3'd2; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = observe();
            checks++;
            if (got !== exp_q[j]) begin
                errors++;
                $display("FAIL repeat_gap[%0d]: got %b expected %b", j, got, exp_q[j]);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_halt();
        obs_t got;
        logic [7:0] p2;
        build_exp(8'hB2, 7, 0, 2);
        bus.pattern = 8'hB2; bus.len = 3'd7; bus.repeat_cnt = 4'd0; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = observe();
            checks++;
            if (got !== exp_q[j]) begin
                errors++;
                $display("FAIL halt_third_bit[%0d]: got %b expected %b", j, got, exp_q[j]);
            end
            bus.halt = (j == 2);
            @(posedge clock); #1;
        end
        bus.halt = 1'b0;
        p2 = 8'($urandom);
        build_exp(p2, 5, 1, -1);
        bus.pattern = p2; bus.len = 3'd5; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = observe();
            checks++;
            if (got !== exp_q[j]) begin
                errors++;
                $display("FAIL after_halt[%0d]: got %b expected %b", j, got, exp_q[j]);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_ignore_start();
        obs_t got;
        logic [7:0] stream = '0;
        build_exp(8'hB2, 7, 0, -1);
        bus.pattern = 8'hB2; bus.len = 3'd7; bus.repeat_cnt = 4'd0; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = observe();
            if (got.valid) stream = {stream[6:0], got.out};
            checks++;
            if (got !== exp_q[j]) begin
                errors++;
                $display("FAIL ignore_start[%0d]: got %b expected %b", j, got, exp_q[j]);
            end
            if (exp_q[j].busy) begin
                bus.start      = (j == 3) ? 1'b1 : 1'($urandom_range(0, 1));
                bus.pattern    = 8'($urandom);
                bus.len        = 3'($urandom);
                bus.repeat_cnt = 4'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock); #1;
        end
        bus.start = 1'b0;
        checks++;
        if (stream !== 8'hB2) begin
            errors++;
            $display("FAIL ignore_start_stream: got %h expected b2", stream);
        end
    endtask

    task automatic test_len0_rep15();
        obs_t got;
        logic [7:0] p;
        int n_fs = 0;
        int n_done = 0;
        p = 8'($urandom);
        build_exp(p, 0, 15, -1);
        bus.pattern = p; bus.len = 3'd0; bus.repeat_cnt = 4'd15; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = observe();
            if (got.fs) n_fs++;
            if (got.done) n_done++;
            checks++;
            if (got !== exp_q[j]) begin
                errors++;
                $display("FAIL len0_rep15[%0d]: got %b expected %b", j, got, exp_q[j]);
            end
            @(posedge clock); #1;
        end
        checks++;
        if (n_fs != 16 || n_done != 1) begin
            errors++;
            $display("FAIL len0_rep15_counts: got frame_start=%0d done=%0d expected 16 and 1", n_fs, n_done);
        end
    endtask

    task automatic test_random();
        obs_t got;
        for (int it = 0; it < 25; it++) begin
            logic [7:0] p;
            int l, r, n_busy, halt_at;
            bit disturb;
            p       = 8'($urandom);
            l       = int'($urandom_range(0, 7));
            r       = int'($urandom_range(0, 3));
            n_busy  = (l + 1) * (r + 1) + GAP * r + 1;
            halt_at = -1;
            if ($urandom_range(0, 2) == 0) halt_at = int'($urandom_range(0, n_busy - 1));
            disturb = 1'($urandom_range(0, 1));
            build_exp(p, l, r, halt_at);
            bus.pattern = p; bus.len = 3'(l); bus.repeat_cnt = 4'(r); bus.start = 1'b1;
            @(posedge clock); #1;
            bus.start = 1'b0;
            for (int j = 0; j < exp_q.size(); j++) begin
                got = observe();
                checks++;
                if (got !== exp_q[j]) begin
                    errors++;
                    $display("FAIL random[%0d][%0d]: got %b expected %b (p=%h l=%0d r=%0d halt_at=%0d)",
                             it, j, got, exp_q[j], p, l, r, halt_at);
                end
                bus.halt  = (j == halt_at);
                bus.start = 1'b0;
                if (disturb && exp_q[j].busy) begin
                    bus.start      = 1'($urandom_range(0, 1));
                    bus.pattern    = 8'($urandom);
                    bus.len        = 3'($urandom);
                    bus.repeat_cnt = 4'($urandom);
                end
                if (j == exp_q.size() - 1) break;
                @(posedge clock); #1;
            end
            bus.halt  = 1'b0;
            bus.start = 1'b0;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_gap();
        obs_t got;
        build_exp(8'h05, 2, 1, -1);
        bus.pattern = 8'h05; bus.len = 3'd2; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            got = observe();
            checks++;
            if (got !== exp_q[j]) begin
                errors++;
                $display("FAIL pre_reset[%0d]: got %b expected %b", j, got, exp_q[j]);
            end
            if (j < 3) begin
                @(posedge clock); #1;
            end
        end
        #2;
        reset = 1'b0;
        #1;
        got = observe();
        checks++;
        if (got !== mk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", got, mk(0, 0, 0, 0, 0, 0));
        end
        @(posedge clock); #1;
        reset = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clock); #1;
            got = observe();
            checks++;
            if (got !== mk(0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL post_reset_quiet[%0d]: got %b expected %b", j, got, mk(0, 0, 0, 0, 0, 0));
            end
        end
        build_exp(8'h05, 2, 1, -1);
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            got = observe();
            checks++;
            if (got !== exp_q[j]) begin
                errors++;
                $display("FAIL first_start_after_reset[%0d]: got %b expected %b", j, got, exp_q[j]);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.halt       = 1'b0;
        bus.pattern    = '0;
        bus.len        = '0;
        bus.repeat_cnt = '0;
        test_reset();
        test_halt_idle();
        test_single_frame();
        test_repeat_gap();
        test_halt();
        test_ignore_start();
        test_len0_rep15();
        test_random();
        test_reset_mid_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/my_seq_gen.md
MY_SEQ_GEN -- requirements
Module: my_seq_gen

Interface
REQ-001 SHALL have parameter PAT_W, default 8, pattern register width in bits.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles between repeated frames (legal range 1..15).
REQ-003 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to send a frame burst; sampled only in IDLE.
REQ-006 SHALL have port pattern  input  PAT_W  bits to send; only bits [len:0] are used.
REQ-007 SHALL have port len  input  $clog2(PAT_W)  frame length minus 1 (0 = 1 bit, PAT_W-1 = PAT_W bits).
REQ-008 SHALL have port repeat  input  4  number of extra frames after the first (0 = one frame, 15 = sixteen frames).
REQ-009 SHALL have port halt  input  1  synchronous abort request.
REQ-010 SHALL have port out  output  1  serial bit stream for the downstream detector; 0 when not valid.
REQ-011 SHALL have port valid  output  1  out carries a pattern bit this cycle.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse coincident with the first bit of each frame.
REQ-013 SHALL have port busy  output  1  burst in progress; start is ignored while high.
REQ-014 SHALL have port done  output  1  one-cycle pulse on normal burst completion.
REQ-015 SHALL have port aborted  output  1  one-cycle pulse when halt ends a burst.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, GAP, FIN; all outputs registered.
REQ-017 IDLE with start=1 at edge k SHALL latch pattern, len and repeat, then enter SHIFT; the first bit appears at cycle k+1.
REQ-018 SHIFT SHALL drive out = latched pattern[len-i] for bit index i = 0..len (MSB of the active field first), with valid=1, one bit per cycle.
REQ-019 After the last bit, SHIFT SHALL go to GAP if frames remain, otherwise to FIN.
REQ-020 GAP SHALL hold out=0, valid=0 for exactly GAP_CYCLES cycles, then return to SHIFT with the bit index cleared and the frame counter decremented.
REQ-021 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 busy SHALL be high from cycle k+1 through the FIN cycle inclusive, and low in IDLE.
REQ-023 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-024 halt=1 in SHIFT, GAP or FIN SHALL force IDLE at the next edge: aborted pulses one cycle, done stays low, out=0, valid=0.
REQ-025 halt=1 in IDLE SHALL have no effect; halt and start both high in IDLE SHALL give priority to halt (no burst starts).
REQ-026 Input changes to pattern, len or repeat during a burst SHALL NOT affect the burst in progress.
REQ-027 Total frames sent SHALL equal repeat+1; the frame counter SHALL never wrap.

Reset
REQ-028 reset low SHALL asynchronously force IDLE, out=0, valid=0, frame_start=0, busy=0, done=0, aborted=0 and clear all latched fields and counters.
REQ-029 reset asserted mid-burst SHALL drop the burst with no done or aborted pulse.
REQ-030 The first start after reset deasserts SHALL be honoured normally.

Structure
REQ-031 Package my_seq_pkg SHALL hold the state enum, the repeat-counter width (4) and the gap-counter width.
REQ-032 A sub-module my_seq_cnt SHALL provide a loadable down-counter with a zero flag, instantiated for the bit, gap and frame counts.

Verification
REQ-033 pattern=8'hB2, len=7, repeat=0, start at k -> out=1,0,1,1,0,0,1,0 on k+1..k+8 with valid=1; frame_start at k+1; done at k+9.
REQ-034 pattern=8'h05, len=2, repeat=1, GAP_CYCLES=2 -> out=1,0,1 on k+1..k+3, valid=0 on k+4..k+5, out=1,0,1 on k+6..k+8, done at k+9.
REQ-035 halt at the third bit of REQ-033 -> aborted at the next cycle, busy=0, done never asserted, IDLE accepts a new start.
REQ-036 start re-pulsed mid-burst and pattern changed mid-burst -> stream identical to REQ-033.
REQ-037 reset low mid-GAP -> all outputs 0 immediately (asynchronous), no done or aborted pulse.
REQ-038 len=0, repeat=15 -> sixteen single-bit frames separated by GAP_CYCLES, sixteen frame_start pulses, one done pulse.
